// File: rtl/mm_tbl_loader_pkg.sv
// Shared defaults and FSM state encoding for the table loader.
package mm_tbl_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2
    } state_t;

endpackage

// File: rtl/mm_tbl_loader.sv
// Streams len words into a table at base_addr, XOR checksum; MM_TBL_LOADER_READBACK_EN adds readback verify.
// Latency: one write per accepted word; done one cycle after last write (or after last readback data).
// Backpressure: in_ready high only in LOAD; in_valid low stalls without writing.
module mm_tbl_loader
    import mm_tbl_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   count;
    logic              accept;
    logic              last_wr;
    logic              rd_addr_vld;

`ifdef MM_TBL_LOADER_READBACK_EN
    logic              rd_issue;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_acc;

    assign rd_addr_vld = (state == ST_VERIFY) && rd_issue;
`else
    logic unused_mem_dout;

    assign unused_mem_dout = ^mem_dout;
    assign rd_addr_vld     = 1'b0;
`endif

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state != ST_IDLE);
    assign accept   = in_ready && in_valid;
    assign last_wr  = accept && (count == len_q - ONE);
    assign mem_we   = accept;
    assign mem_din  = accept ? in_data : '0;

    // Address wraps naturally in ADDR_W bits; zero whenever the port is not in use.
    always_comb begin
        mem_addr = '0;
        if (accept || rd_addr_vld) begin
            mem_addr = base_q + count[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            count    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            checksum <= '0;
`ifdef MM_TBL_LOADER_READBACK_EN
            rd_issue <= 1'b0;
            rd_vld   <= 1'b0;
            rd_acc   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            base_q   <= base_addr;
                            len_q    <= len;
                            count    <= '0;
                            checksum <= '0;
                            err      <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        checksum <= checksum ^ in_data;
                        if (last_wr) begin
`ifdef MM_TBL_LOADER_READBACK_EN
                            state    <= ST_VERIFY;
                            count    <= '0;
                            rd_issue <= 1'b1;
                            rd_vld   <= 1'b0;
                            rd_acc   <= '0;
`else
                            state    <= ST_IDLE;
                            done     <= 1'b1;
`endif
                        end else begin
                            count <= count + ONE;
                        end
                    end
                end
`ifdef MM_TBL_LOADER_READBACK_EN
                ST_VERIFY: begin
                    // Read data trails its address by one cycle; the final word arrives after issue stops.
                    rd_vld <= rd_issue;
                    if (rd_issue) begin
                        if (count == len_q - ONE) begin
                            rd_issue <= 1'b0;
                        end else begin
                            count <= count + ONE;
                        end
                    end
                    if (rd_vld) begin
                        rd_acc <= rd_acc ^ mem_dout;
                        if (!rd_issue) begin
                            err   <= ((rd_acc ^ mem_dout) != checksum);
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mm_tbl_loader.md
MM_TBL_LOADER -- requirements
Module: mm_tbl_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning table address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning table word width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle load request, sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  first table address, sampled with start.
REQ-008 len  input  ADDR_W+1  word count 0..256, sampled with start.
REQ-009 in_data  input  DATA_W  stream word.
REQ-010 in_valid  input  1  stream word valid.
REQ-011 in_ready  output  1  loader accepts in_data this cycle.
REQ-012 mem_addr  output  ADDR_W  table write/read-port-0 address.
REQ-013 mem_din  output  DATA_W  table write data.
REQ-014 mem_we  output  1  table write enable.
REQ-015 mem_dout  input  DATA_W  table port-0 registered read data, 1-cycle latency.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 err  output  1  sticky until next accepted start: len==0 or readback mismatch.
REQ-019 checksum  output  DATA_W  XOR of all words written in the last load.

Function
REQ-020 SHALL implement FSM IDLE -> LOAD -> (VERIFY) -> IDLE.
REQ-021 IDLE: start with len!=0 -> LOAD, clear checksum/err/counter; start with len==0 -> set err, pulse done, stay IDLE.
REQ-022 LOAD: in_ready=1; word is accepted when in_valid&&in_ready; same cycle mem_we=1, mem_addr=base_addr+count (mod 2^ADDR_W, wraps 255->0), mem_din=in_data, checksum^=in_data.
REQ-023 Outside accepted transfers mem_we SHALL be 0; in_valid=0 stalls with no write.
REQ-024 After the len-th accepted word: go to IDLE and pulse done the next cycle (no readback build), or VERIFY.
REQ-025 Zero bubbles: one word per cycle at sustained in_valid=1; len=256 completes in 256 accept cycles.
REQ-026 in_ready SHALL be 0 in IDLE and VERIFY; start during busy SHALL be ignored.
REQ-027 Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0, err=0, checksum=0, state IDLE.

Reset
REQ-028 rst_n low at any time, including mid-LOAD/VERIFY, SHALL abort the operation immediately to reset values; partially written table contents remain undefined-but-untouched.
REQ-029 Deassertion SHALL be treated as synchronous by an external synchronizer; the block needs no first-cycle exception.

Configuration
REQ-030 Macro MM_TBL_LOADER_READBACK_EN defined: after LOAD, VERIFY reads addresses base..base+len-1 on port 0 (mem_we=0), XORs mem_dout one cycle after each address, and after the last data sets err if result != checksum, then pulses done.
REQ-031 Macro undefined: no VERIFY state, mem_dout unused, done pulses one cycle after the last write.

Structure
REQ-032 Shared package SHALL hold ADDR_W/DATA_W defaults and the FSM state encoding (IDLE, LOAD, VERIFY).
REQ-033 Single module; no sub-module; counter, checksum and FSM inline.

Verification
REQ-034 base=0x10, len=4, words 0x1111,0x2222,0x4444,0x8888 back-to-back -> writes at 0x10..0x13, checksum=0xFFFF, done 1 cycle after last write, err=0.
REQ-035 base=0xFE, len=3 -> writes at 0xFE,0xFF,0x00 (wrap).
REQ-036 len=0 start -> err=1, done pulse next cycle, no mem_we, busy stays 0.
REQ-037 len=4 with in_valid toggling 1,0,1,0,... -> exactly 4 writes, addresses consecutive, no write on idle cycles; start asserted mid-load is ignored.
REQ-038 rst_n pulsed low after 2 of 4 words -> all outputs at reset values same cycle, state IDLE, later start works normally.
REQ-039 READBACK_EN, memory model corrupts one word to 0x0000 -> err=1 with done; uncorrupted run -> err=0.
